shift_tx_ctrl: RTL

- Controller that sequences an internal WIDTH-bit shift register to serialize parallel words onto a single serial line.
- Upstream logic hands words over a valid/ready handshake. The block loads each word, shifts it out MSB- or LSB-first at a programmable bit period, then inserts a one-bit-period gap and signals completion.
- Sits between a parallel data producer and a serial output pin or downstream serial receiver.

---
 rtl/shift_tx_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/shift_tx_ctrl.sv
// Parallel-to-serial transmit controller: accepts a word over valid/ready, shifts it out
// MSB- or LSB-first at a programmable bit period, then idles for one bit period and pulses done.
module shift_tx_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_msb_first,
  input  logic             i_abort,
  output logic             o_sdo,
  output logic             o_bit_stb,
  output logic             o_frame,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic             o_done,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               msb_q, msb_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               sdo_q, sdo_d;
  logic               bit_stb_q, bit_stb_d;
  logic               done_q, done_d;

  logic               period_end;

  // Counter is compared before increment, so div at its maximum never wraps mid-bit.
  assign period_end = (div_cnt_q == div_q);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    div_d     = div_q;
    msb_d     = msb_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sdo_d     = sdo_q;
    bit_stb_d = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          state_d   = StShift;
          sr_d      = i_data;
          div_d     = i_div;
          msb_d     = i_msb_first;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          sdo_d     = i_msb_first ? i_data[WIDTH-1] : i_data[0];
          bit_stb_d = 1'b1;
        end
      end

      StShift: begin
        if (i_abort) begin
          state_d   = StIdle;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          sdo_d     = 1'b0;
        end else if (period_end) begin
          div_cnt_d = '0;
          if (bit_cnt_q != LastBit) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            bit_stb_d = 1'b1;
            if (msb_q) begin
              sr_d  = sr_q << 1;
              sdo_d = sr_q[WIDTH-2];
            end else begin
              sr_d  = sr_q >> 1;
              sdo_d = sr_q[1];
            end
          end else begin
            state_d   = StGap;
            bit_cnt_d = '0;
            sdo_d     = 1'b0;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      StGap: begin
        if (i_abort) begin
          state_d   = StIdle;
          div_cnt_d = '0;
        end else if (period_end) begin
          state_d   = StIdle;
          div_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d   = StIdle;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        sdo_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      div_q     <= '0;
      msb_q     <= 1'b0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sdo_q     <= 1'b0;
      bit_stb_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      div_q     <= div_d;
      msb_q     <= msb_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sdo_q     <= sdo_d;
      bit_stb_q <= bit_stb_d;
      done_q    <= done_d;
    end
  end

  assign o_ready   = (state_q == StIdle);
  assign o_busy    = (state_q != StIdle);
  assign o_frame   = (state_q == StShift);
  assign o_sdo     = sdo_q;
  assign o_bit_stb = bit_stb_q;
  assign o_bit_cnt = bit_cnt_q;
  assign o_done    = done_q;

endmodule
